// File: rtl/matmul_apb_master_pkg.sv
// -----------------------------------------------------------------------------
// matmul_apb_master_pkg
// Purpose : Shared constants for the matmul APB initiator. This package holds
//           the default bus geometry used by the matmul target and the FSM
//           state encoding of the initiator.
// Contents: - BUS_WIDTH_DEF / ADDR_WIDTH_DEF / MAX_DIM_DEF : bus geometry
//           - TIMEOUT_CYCLES_DEF : default pready wait limit
//           - ST_IDLE / ST_SETUP / ST_ACCESS / ST_RESP : 2-bit FSM states
//           - strb_mask() : drops strobes for reads
// -----------------------------------------------------------------------------
package matmul_apb_master_pkg;

  localparam int BUS_WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF     = 16;
  localparam int MAX_DIM_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // APB requires pstrb to be all-zero on read transfers.
  function automatic logic [MAX_DIM_DEF-1:0] strb_mask(
    input logic                   write,
    input logic [MAX_DIM_DEF-1:0] strb
  );
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/matmul_apb_master_if.sv
// -----------------------------------------------------------------------------
// matmul_apb_master_if
// Purpose : Bundles the command channel, response channel and APB bus of the
//           matmul APB initiator. Signal suffixes (_i/_o) are given from the
//           initiator's point of view.
// Modports: master - the initiator (matmul_apb_master)
//           slave  - the environment: command source, response sink and
//                    APB target
// Signals : cmd_*  valid/ready command request
//           rsp_*  valid/ready response (rdata, err, timeout)
//           p*     APB psel/penable/pwrite/pstrb/pwdata/paddr/pready/
//                  pslverr/prdata
// -----------------------------------------------------------------------------
interface matmul_apb_master_if
  import matmul_apb_master_pkg::*;
#(
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_DIM    = MAX_DIM_DEF
);

  // Command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [BUS_WIDTH-1:0]  cmd_wdata_i;
  logic [MAX_DIM-1:0]    cmd_strb_i;

  // Response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [BUS_WIDTH-1:0]  rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  // APB
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [MAX_DIM-1:0]    pstrb_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic                  pready_i;
  logic                  pslverr_i;
  logic [BUS_WIDTH-1:0]  prdata_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o,
    input  pready_i, pslverr_i, prdata_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o,
    output pready_i, pslverr_i, prdata_i
  );

endinterface

// File: rtl/matmul_apb_master.sv
// -----------------------------------------------------------------------------
// matmul_apb_master
// Purpose : APB initiator driving the matmul accelerator's APB target. Takes
//           one command at a time, runs a SETUP->ACCESS transfer (with wait
//           states and a pready timeout) and returns read data plus
//           error/timeout status on a response channel.
// Ports   : clk_i   - clock, rising edge
//           rst_ni  - asynchronous active-low reset
//           bus     - matmul_apb_master_if.master (command, response, APB)
//           busy_o  - high whenever the FSM is not IDLE
// Notes   : All bus and response outputs are decoded from the state, so they
//           read 0 in reset and outside the phase that owns them; the captured
//           command/response payload registers therefore need no reset.
// -----------------------------------------------------------------------------
module matmul_apb_master
  import matmul_apb_master_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int MAX_DIM        = MAX_DIM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  matmul_apb_master_if.master bus,
  output logic                busy_o
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  // Control state
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Captured command
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [MAX_DIM-1:0]    strb_q, strb_d;

  // Captured response
  logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;

  logic                  in_xfer;
  logic                  in_resp;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          write_d = bus.cmd_write_i;
          addr_d  = bus.cmd_addr_i;
          // Reads carry neither data nor strobes onto the bus.
          wdata_d = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
          strb_d  = bus.cmd_write_i ? bus.cmd_strb_i  : '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        cnt_d   = CNT_ONE;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.pready_i) begin
          // An erroring read returns no data.
          rdata_d = (!write_q && !bus.pslverr_i) ? bus.prdata_i : '0;
          err_d   = bus.pslverr_i;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
    rdata_q <= rdata_d;
    err_q   <= err_d;
    tmo_q   <= tmo_d;
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  assign in_xfer = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign in_resp = (state_q == ST_RESP);

  assign bus.cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o            = (state_q != ST_IDLE);

  assign bus.psel_o        = in_xfer;
  assign bus.penable_o     = (state_q == ST_ACCESS);
  assign bus.pwrite_o      = in_xfer & write_q;
  assign bus.paddr_o       = in_xfer ? addr_q  : '0;
  assign bus.pwdata_o      = in_xfer ? wdata_q : '0;
  assign bus.pstrb_o       = in_xfer ? strb_q  : '0;

  assign bus.rsp_valid_o   = in_resp;
  assign bus.rsp_rdata_o   = in_resp ? rdata_q : '0;
  assign bus.rsp_err_o     = in_resp & err_q;
  assign bus.rsp_timeout_o = in_resp & tmo_q;

endmodule
